// File: rtl/lsu_keypad.sv
// Load/store unit with a 256-word data RAM and a memory-mapped keypad FIFO.
// Loads return one cycle after the request; stores to RAM take effect on the request edge.
module lsu_keypad (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic        i_lsu_wren,
  input  logic        i_lsu_rden,
  input  logic [2:0]  i_funct3,
  input  logic        i_key_valid,
  input  logic [3:0]  i_key_code,
  output logic [31:0] o_ld_data,
  output logic        o_ld_valid,
  output logic        o_misaligned,
  output logic        o_key_pending
);

  logic [31:0] ram [256];
  logic [3:0]  keyMem [4];
  logic [1:0]  wrPtr, rdPtr;
  logic [2:0]  count;
  logic        overflow;

  logic        isRam, isKeyData, isKeyStat, sizeOk, misaligned;
  logic        access, loadReq, loadOk, storeOk;
  logic        pop, push, overflowSet, overflowClr;
  logic [31:0] ramWord, ldNext, wrData;
  logic [3:0]  byteEn;
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;

  // Address decode and access legality; keypad registers accept word accesses only
  always_comb begin
    isRam     = (i_lsu_addr[31:10] == 22'd0);
    isKeyData = (i_lsu_addr == 32'h0000_7000);
    isKeyStat = (i_lsu_addr == 32'h0000_7004);
    case (i_funct3)
      3'b000, 3'b100: sizeOk = 1'b1;
      3'b001, 3'b101: sizeOk = ~i_lsu_addr[0];
      3'b010:         sizeOk = (i_lsu_addr[1:0] == 2'b00);
      default:        sizeOk = 1'b0;
    endcase
    access     = i_lsu_wren | i_lsu_rden;
    misaligned = access & (~sizeOk | ((isKeyData | isKeyStat) & (i_funct3 != 3'b010)));
    loadReq    = i_lsu_rden & ~i_lsu_wren;
    loadOk     = loadReq & ~misaligned;
    storeOk    = i_lsu_wren & ~misaligned;
  end

  // FIFO control: a pop only happens on a nonempty FIFO, and a pop frees room for a push
  always_comb begin
    pop         = loadOk & isKeyData & (count != 3'd0);
    push        = i_key_valid & ((count != 3'd4) | pop);
    overflowSet = i_key_valid & (count == 3'd4) & ~pop;
    overflowClr = storeOk & isKeyStat;
  end

  // Lane extraction and extension of the load result
  always_comb begin
    ramWord = ram[i_lsu_addr[9:2]];
    case (i_lsu_addr[1:0])
      2'd0:    ldByte = ramWord[7:0];
      2'd1:    ldByte = ramWord[15:8];
      2'd2:    ldByte = ramWord[23:16];
      default: ldByte = ramWord[31:24];
    endcase
    ldHalf = i_lsu_addr[1] ? ramWord[31:16] : ramWord[15:0];
    ldNext = 32'd0;
    if (loadOk) begin
      if (isRam) begin
        case (i_funct3)
          3'b000:  ldNext = {{24{ldByte[7]}}, ldByte};
          3'b100:  ldNext = {24'd0, ldByte};
          3'b001:  ldNext = {{16{ldHalf[15]}}, ldHalf};
          3'b101:  ldNext = {16'd0, ldHalf};
          default: ldNext = ramWord;
        endcase
      end else if (isKeyData) begin
        if (count != 3'd0) ldNext = {27'd0, 1'b1, keyMem[rdPtr]};
      end else if (isKeyStat) begin
        ldNext = {23'd0, overflow, 5'd0, count};
      end
    end
  end

  // Store byte enables with the data replicated across the lanes
  always_comb begin
    byteEn = 4'b0000;
    wrData = i_st_data;
    if (storeOk && isRam) begin
      case (i_funct3)
        3'b000, 3'b100: begin
          byteEn = 4'b0001 << i_lsu_addr[1:0];
          wrData = {4{i_st_data[7:0]}};
        end
        3'b001, 3'b101: begin
          byteEn = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
          wrData = {2{i_st_data[15:0]}};
        end
        default: byteEn = 4'b1111;
      endcase
    end
  end

  // RAM and FIFO storage carry no reset; only the control state does
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byteEn[i]) ram[i_lsu_addr[9:2]][i*8 +: 8] <= wrData[i*8 +: 8];
    end
    if (push) keyMem[wrPtr] <= i_key_code;
  end

  // FIFO pointers, occupancy and the sticky overflow flag; a same-cycle overflow beats the clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wrPtr    <= 2'd0;
      rdPtr    <= 2'd0;
      count    <= 3'd0;
      overflow <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + 2'd1;
      if (pop)  rdPtr <= rdPtr + 2'd1;
      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;
      if (overflowSet)      overflow <= 1'b1;
      else if (overflowClr) overflow <= 1'b0;
    end
  end

  // Registered load response and rejection pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ld_data    <= 32'd0;
      o_ld_valid   <= 1'b0;
      o_misaligned <= 1'b0;
    end else begin
      o_ld_data    <= ldNext;
      o_ld_valid   <= loadReq;
      o_misaligned <= misaligned;
    end
  end

  assign o_key_pending = (count != 3'd0);

endmodule

// File: tb/tb_lsu_keypad.sv
// Directed self-checking bench for lsu_keypad: RAM lanes, misalignment, keypad FIFO and reset.
module tb_lsu_keypad;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_lsu_addr = '0;
  logic [31:0] i_st_data = '0;
  logic        i_lsu_wren = 1'b0;
  logic        i_lsu_rden = 1'b0;
  logic [2:0]  i_funct3 = '0;
  logic        i_key_valid = 1'b0;
  logic [3:0]  i_key_code = '0;
  logic [31:0] o_ld_data;
  logic        o_ld_valid;
  logic        o_misaligned;
  logic        o_key_pending;

  int compareCount = 0;
  int failCount = 0;

  lsu_keypad dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_lsu_addr(i_lsu_addr), .i_st_data(i_st_data),
    .i_lsu_wren(i_lsu_wren), .i_lsu_rden(i_lsu_rden), .i_funct3(i_funct3),
    .i_key_valid(i_key_valid), .i_key_code(i_key_code), .o_ld_data(o_ld_data),
    .o_ld_valid(o_ld_valid), .o_misaligned(o_misaligned), .o_key_pending(o_key_pending)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One request cycle: drive on the falling edge, return 1 time unit after the capturing edge
  task automatic applyStimulus(input logic wr, input logic rd, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] data,
                               input logic kv, input logic [3:0] kc);
    @(negedge i_clk);
    i_lsu_wren = wr; i_lsu_rden = rd; i_funct3 = f3;
    i_lsu_addr = addr; i_st_data = data;
    i_key_valid = kv; i_key_code = kc;
    @(posedge i_clk);
    #1;
    i_lsu_wren = 1'b0; i_lsu_rden = 1'b0; i_key_valid = 1'b0;
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, 1'b0, f3, addr, data, 1'b0, 4'h0);
  endtask

  task automatic loadCheck(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] expected);
    applyStimulus(1'b0, 1'b1, f3, addr, 32'd0, 1'b0, 4'h0);
    checkOutput(tag, o_ld_data, expected);
    checkOutput({tag, "_valid"}, {31'd0, o_ld_valid}, 32'd1);
    checkOutput({tag, "_mis"}, {31'd0, o_misaligned}, 32'd0);
  endtask

  task automatic pushKey(input logic [3:0] code);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'd0, 32'd0, 1'b1, code);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("rst_data", o_ld_data, 32'd0);
    checkOutput("rst_valid", {31'd0, o_ld_valid}, 32'd0);
    checkOutput("rst_mis", {31'd0, o_misaligned}, 32'd0);
    checkOutput("rst_pending", {31'd0, o_key_pending}, 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Lane selection and extension
    store(3'b010, 32'h010, 32'h80F0_1234);
    loadCheck("lb_13", 3'b000, 32'h013, 32'hFFFF_FF80);
    loadCheck("lbu_13", 3'b100, 32'h013, 32'h0000_0080);
    loadCheck("lh_12", 3'b001, 32'h012, 32'hFFFF_80F0);
    loadCheck("lhu_10", 3'b101, 32'h010, 32'h0000_1234);
    loadCheck("lw_10", 3'b010, 32'h010, 32'h80F0_1234);
    applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 4'h0);
    checkOutput("valid_drop", {31'd0, o_ld_valid}, 32'd0);

    // Partial stores
    store(3'b010, 32'h020, 32'h0000_0000);
    store(3'b000, 32'h021, 32'h0000_00AB);
    loadCheck("sb_21", 3'b010, 32'h020, 32'h0000_AB00);
    store(3'b001, 32'h022, 32'hFFFF_5555);
    loadCheck("sh_22", 3'b010, 32'h020, 32'h5555_AB00);

    // Misaligned and unsupported accesses
    store(3'b010, 32'h004, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h006, 32'd0, 1'b0, 4'h0);
    checkOutput("mis_lw_data", o_ld_data, 32'd0);
    checkOutput("mis_lw_valid", {31'd0, o_ld_valid}, 32'd1);
    checkOutput("mis_lw_flag", {31'd0, o_misaligned}, 32'd1);
    store(3'b001, 32'h005, 32'h0000_1111);
    checkOutput("mis_sh_flag", {31'd0, o_misaligned}, 32'd1);
    checkOutput("mis_sh_valid", {31'd0, o_ld_valid}, 32'd0);
    applyStimulus(1'b0, 1'b1, 3'b011, 32'h004, 32'd0, 1'b0, 4'h0);
    checkOutput("f3_011_flag", {31'd0, o_misaligned}, 32'd1);
    loadCheck("word1_kept", 3'b010, 32'h004, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h004, 32'h0102_0304, 1'b0, 4'h0);
    checkOutput("wr_rd_novalid", {31'd0, o_ld_valid}, 32'd0);
    loadCheck("wr_rd_stored", 3'b010, 32'h004, 32'h0102_0304);
    loadCheck("unmapped", 3'b010, 32'h0000_5000, 32'd0);

    // Keypad FIFO fill, overflow and drain
    for (int k = 1; k <= 5; k++) pushKey(4'(k));
    checkOutput("pending_full", {31'd0, o_key_pending}, 32'd1);
    loadCheck("stat_ovf", 3'b010, 32'h7004, 32'h0000_0104);
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h7000, 32'd0, 1'b0, 4'h0);
    checkOutput("keydata_lb_mis", {31'd0, o_misaligned}, 32'd1);
    for (int k = 1; k <= 4; k++) begin
      loadCheck($sformatf("pop%0d", k), 3'b010, 32'h7000, 32'h10 + 32'(k));
      checkOutput($sformatf("pend%0d", k), {31'd0, o_key_pending}, (k == 4) ? 32'd0 : 32'd1);
    end
    loadCheck("pop_empty", 3'b010, 32'h7000, 32'd0);
    loadCheck("stat_sticky", 3'b010, 32'h7004, 32'h0000_0100);
    store(3'b010, 32'h7004, 32'd0);
    loadCheck("stat_clr", 3'b010, 32'h7004, 32'd0);

    // Full FIFO with simultaneous push and pop; overflow beats clear
    for (int k = 10; k <= 13; k++) pushKey(4'(k));
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h7000, 32'd0, 1'b1, 4'h9);
    checkOutput("full_pushpop", o_ld_data, 32'h0000_001A);
    loadCheck("full_stat", 3'b010, 32'h7004, 32'h0000_0004);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h7004, 32'd0, 1'b1, 4'hE);
    loadCheck("ovf_wins", 3'b010, 32'h7004, 32'h0000_0104);
    store(3'b010, 32'h7004, 32'hFFFF_FFFF);
    loadCheck("ovf_clr2", 3'b010, 32'h7004, 32'h0000_0004);
    loadCheck("drain_b", 3'b010, 32'h7000, 32'h0000_001B);
    loadCheck("drain_c", 3'b010, 32'h7000, 32'h0000_001C);
    loadCheck("drain_d", 3'b010, 32'h7000, 32'h0000_001D);
    loadCheck("drain_9", 3'b010, 32'h7000, 32'h0000_0019);

    // Push into empty FIFO while popping
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h7000, 32'd0, 1'b1, 4'h5);
    checkOutput("empty_pushpop", o_ld_data, 32'd0);
    loadCheck("empty_pp_stat", 3'b010, 32'h7004, 32'h0000_0001);
    pushKey(4'h6);

    // Reset asserted mid-load with two keys queued
    @(negedge i_clk);
    i_lsu_rden = 1'b1; i_funct3 = 3'b010; i_lsu_addr = 32'h7000;
    @(posedge i_clk);
    #1;
    checkOutput("pre_rst_data", o_ld_data, 32'h0000_0015);
    #1;
    i_rst = 1'b1;
    #1;
    checkOutput("async_data", o_ld_data, 32'd0);
    checkOutput("async_valid", {31'd0, o_ld_valid}, 32'd0);
    checkOutput("async_pending", {31'd0, o_key_pending}, 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_lsu_rden = 1'b0;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    checkOutput("post_rst_valid", {31'd0, o_ld_valid}, 32'd0);
    loadCheck("post_rst_stat", 3'b010, 32'h7004, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
